// File: rtl/ss_pkg.sv
// Shared types and constants for the save-state sequencer.
package ss_pkg;
  localparam int SS_AW      = 8;
  localparam int SS_LEN_DEF = 128;

  typedef enum logic [2:0] {IDLE, S_SET, S_OUT, L_WAIT, L_WE, L_GAP, FIN} ss_state_e;

  // Width of a down-counter able to hold max(a, b); never below one bit.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction
endpackage

// File: rtl/ss_wait_cnt.sv
// Loadable down-counter with zero flag; shared by read-wait and write-hold timing.
module ss_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  assign zero = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load)          cnt_d = load_val;
    else if (en && !zero) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ss_stream_seq.sv
// Save-state sequencer: streams mapper state out on save, writes a byte stream back on load,
// holding each write strobe across a falling M2 edge.
module ss_stream_seq
  import ss_pkg::*;
#(
  parameter int SS_LEN  = SS_LEN_DEF,
  parameter int RD_WAIT = 2,
  parameter int WE_HOLD = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m2_fall,
  input  logic       save_req,
  input  logic       load_req,
  output logic       busy,
  output logic       done,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] out_dat,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_dat,
  input  logic       in_valid,
  output logic       in_ready
);
  localparam int                 CW      = cnt_w(RD_WAIT, WE_HOLD);
  localparam logic [SS_AW-1:0]   LAST    = SS_AW'(SS_LEN - 1);
  localparam logic [CW-1:0]      RD_LOAD = CW'(RD_WAIT);
  // Loaded on the m2_fall cycle itself, so one less than the number of extra cycles.
  localparam logic [CW-1:0]      WE_LOAD = CW'((WE_HOLD > 0) ? WE_HOLD - 1 : 0);

  ss_state_e        state_q, state_d;
  logic [SS_AW-1:0] addr_q, addr_d;
  logic [7:0]       out_dat_q, out_dat_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       ss_wdat_q, ss_wdat_d;
  logic             armed_q, armed_d;

  logic             cnt_load, cnt_en, cnt_zero;
  logic [CW-1:0]    cnt_val;

  ss_wait_cnt #(.W(CW)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    out_dat_d   = out_dat_q;
    out_valid_d = out_valid_q;
    ss_wdat_d   = ss_wdat_q;
    armed_d     = armed_q;
    cnt_load    = 1'b0;
    cnt_val     = RD_LOAD;
    cnt_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (save_req) begin
          state_d  = S_SET;
          addr_d   = '0;
          cnt_load = 1'b1;
        end else if (load_req) begin
          state_d = L_WAIT;
          addr_d  = '0;
        end
      end
      S_SET: begin
        if (cnt_zero) begin
          out_dat_d   = ss_rdat;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (addr_q == LAST) begin
            state_d = FIN;
          end else begin
            addr_d   = addr_q + SS_AW'(1);
            state_d  = S_SET;
            cnt_load = 1'b1;
          end
        end
      end
      L_WAIT: begin
        if (in_valid) begin
          ss_wdat_d = in_dat;
          armed_d   = 1'b0;
          state_d   = L_WE;
        end
      end
      L_WE: begin
        // Only an m2_fall seen while the strobe is already up starts the hold count.
        if (!armed_q) begin
          if (m2_fall) begin
            if (WE_HOLD == 0) begin
              state_d = L_GAP;
            end else begin
              armed_d  = 1'b1;
              cnt_load = 1'b1;
              cnt_val  = WE_LOAD;
            end
          end
        end else if (cnt_zero) begin
          armed_d = 1'b0;
          state_d = L_GAP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      L_GAP: begin
        if (addr_q == LAST) begin
          state_d = FIN;
        end else begin
          addr_d  = addr_q + SS_AW'(1);
          state_d = L_WAIT;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      out_dat_q   <= '0;
      out_valid_q <= 1'b0;
      ss_wdat_q   <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_dat_q   <= out_dat_d;
      out_valid_q <= out_valid_d;
      ss_wdat_q   <= ss_wdat_d;
      armed_q     <= armed_d;
    end
  end

  // Strobe and mode decode straight from state so reset drops them without a clock.
  assign busy      = (state_q != IDLE);
  assign ss_act    = busy;
  assign done      = (state_q == FIN);
  assign ss_we     = (state_q == L_WE);
  assign in_ready  = (state_q == L_WAIT);
  assign ss_addr   = addr_q;
  assign ss_wdat   = ss_wdat_q;
  assign out_dat   = out_dat_q;
  assign out_valid = out_valid_q;
endmodule
